// File: rtl/key_event_matrix.sv
// Key matrix emulator: live key events plus an auto-type FIFO player.
// The host scans rows with active-low addr_sel and reads active-low key_data.
module key_event_matrix #(
    parameter  int ROWS        = 8,
    parameter  int COLS        = 5,
    parameter  int DEPTH       = 16,
    parameter  int HOLD_CYCLES = 7000000,
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int EW          = 1 + RW + CW,
    localparam int AW          = $clog2(DEPTH),
    localparam int NW          = AW + 1
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            live_valid,
    input  logic            live_press,
    input  logic [RW-1:0]   live_row,
    input  logic [CW-1:0]   live_col,
    input  logic            auto_wr,
    input  logic [EW-1:0]   auto_data,
    input  logic            auto_clear,
    input  logic [ROWS-1:0] addr_sel,
    output logic [COLS-1:0] key_data,
    output logic            auto_full,
    output logic [NW-1:0]   auto_count,
    output logic            busy,
    output logic            overflow
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        GAP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [HW-1:0]   hold_q;
    logic [HW-1:0]   hold_d;
    logic            pop;

    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [NW-1:0]   count_q;
    logic            push;

    logic [COLS-1:0] matrix [ROWS];

    logic [EW-1:0]   head;
    logic            head_press;
    int              head_r;
    int              head_c;
    int              live_r;
    int              live_c;
    logic            head_ok;
    logic            live_ok;
    logic            auto_hit;
    logic            live_hit;

    assign head       = fifo_mem[rd_ptr];
    assign head_press = head[EW-1];
    assign head_r     = int'(head[EW-2:CW]);
    assign head_c     = int'(head[CW-1:0]);
    assign live_r     = int'(live_row);
    assign live_c     = int'(live_col);

    // Out-of-range coordinates are dropped without touching the matrix.
    assign head_ok  = (head_r < ROWS) && (head_c < COLS);
    assign live_ok  = (live_r < ROWS) && (live_c < COLS);
    assign auto_hit = pop && head_ok;
    assign live_hit = live_valid && live_ok;

    assign auto_full  = (count_q == NW'(DEPTH));
    assign auto_count = count_q;
    assign busy       = (state_q != IDLE);
    assign push       = auto_wr && !auto_full;

    // Player state and hold counter registers; clear acts like a soft reset.
    always_ff @(posedge clk_sys) begin
        if (reset || auto_clear) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Player next state: pop one entry per APPLY, then wait out the hold.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                pop     = 1'b1;
                hold_d  = HW'(HOLD_CYCLES - 1);
                state_d = GAP;
            end
            GAP: begin
                if (hold_q == '0) begin
                    state_d = (count_q != '0) ? APPLY : IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage; a write is only accepted when there is room.
    always_ff @(posedge clk_sys) begin
        if (push && !reset && !auto_clear) begin
            fifo_mem[wr_ptr] <= auto_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_sys) begin
        if (reset || auto_clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + NW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - NW'(1);
            end
        end
    end

    // Sticky overflow on a write that found the FIFO full; clear keeps it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (auto_wr && auto_full && !auto_clear) begin
            overflow <= 1'b1;
        end
    end

    // Matrix bits, 0 = pressed; live wins over auto on the same bit.
    always_ff @(posedge clk_sys) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (reset || auto_clear) begin
                    matrix[r][c] <= 1'b1;
                end else if (live_hit && live_r == r && live_c == c) begin
                    matrix[r][c] <= ~live_press;
                end else if (auto_hit && head_r == r && head_c == c) begin
                    matrix[r][c] <= ~head_press;
                end
            end
        end
    end

    // Column read-back: AND of every selected row, all ones when none.
    always_comb begin
        key_data = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!addr_sel[r]) begin
                key_data = key_data & matrix[r];
            end
        end
    end

endmodule

// File: tb/tb_key_event_matrix.sv
// Directed bench for key_event_matrix with ROWS=8, COLS=5, DEPTH=4,
// HOLD_CYCLES=4; expected values are hand-computed per cycle.
module tb_key_event_matrix;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       live_valid;
    logic       live_press;
    logic [2:0] live_row;
    logic [2:0] live_col;
    logic       auto_wr;
    logic [6:0] auto_data;
    logic       auto_clear;
    logic [7:0] addr_sel;
    logic [4:0] key_data;
    logic       auto_full;
    logic [2:0] auto_count;
    logic       busy;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    key_event_matrix #(
        .ROWS(8),
        .COLS(5),
        .DEPTH(4),
        .HOLD_CYCLES(4)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .live_valid(live_valid),
        .live_press(live_press),
        .live_row(live_row),
        .live_col(live_col),
        .auto_wr(auto_wr),
        .auto_data(auto_data),
        .auto_clear(auto_clear),
        .addr_sel(addr_sel),
        .key_data(key_data),
        .auto_full(auto_full),
        .auto_count(auto_count),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic live(input bit p, input int r, input int c);
        live_valid = 1'b1;
        live_press = p;
        live_row   = 3'(r);
        live_col   = 3'(c);
    endtask

    task automatic push(input bit p, input int r, input int c);
        auto_wr   = 1'b1;
        auto_data = {p, 3'(r), 3'(c)};
    endtask

    initial begin
        reset      = 1'b1;
        live_valid = 1'b0;
        live_press = 1'b0;
        live_row   = '0;
        live_col   = '0;
        auto_wr    = 1'b0;
        auto_data  = '0;
        auto_clear = 1'b0;
        addr_sel   = 8'h00;
        tick();
        tick();
        check("rst_kd", key_data, 5'b11111);
        check("rst_cnt", auto_count, 0);
        check("rst_full", auto_full, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;

        // Live press / release on row 6.
        addr_sel = 8'hBF;
        live(1, 6, 0);
        tick();
        live_valid = 1'b0;
        check("live_press", key_data, 5'b11110);
        addr_sel = 8'hFF;
        #1;
        check("live_unsel", key_data, 5'b11111);
        addr_sel = 8'hBF;
        tick();
        tick();
        tick();
        check("live_hold", key_data, 5'b11110);
        live(0, 6, 0);
        tick();
        live_valid = 1'b0;
        check("live_release", key_data, 5'b11111);

        // Two auto events: press then release of (0,1).
        addr_sel = 8'hFE;
        push(1, 0, 1);
        tick();
        push(0, 0, 1);
        tick();
        auto_wr = 1'b0;
        for (int c = 2; c <= 13; c++) begin
            check($sformatf("play_kd_c%0d", c), key_data,
                  (c >= 3 && c < 8) ? 5'b11101 : 5'b11111);
            check($sformatf("play_busy_c%0d", c), busy,
                  (c >= 2 && c < 12) ? 1 : 0);
            tick();
        end

        // Fill during GAP; fifth write collides with a pop and is dropped.
        push(1, 0, 0);
        tick();
        auto_wr = 1'b0;
        tick();
        tick();
        check("ovf_first", key_data, 5'b11110);
        push(1, 0, 1);
        tick();
        push(1, 0, 2);
        tick();
        push(1, 0, 3);
        tick();
        push(1, 0, 4);
        tick();
        check("ovf_cnt4", auto_count, 4);
        check("ovf_full", auto_full, 1);
        check("ovf_pre", overflow, 0);
        push(0, 0, 0);
        tick();
        auto_wr = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_cnt3", auto_count, 3);
        check("ovf_notfull", auto_full, 0);
        check("ovf_e1", key_data, 5'b11100);
        repeat (5) tick();
        check("ovf_e2", key_data, 5'b11000);
        repeat (5) tick();
        check("ovf_e3", key_data, 5'b10000);
        repeat (5) tick();
        check("ovf_e4", key_data, 5'b00000);
        repeat (4) tick();
        check("ovf_idle", busy, 0);
        check("ovf_empty", auto_count, 0);
        tick();
        check("ovf_dropped", key_data, 5'b00000);

        // Live vs auto collisions on row 7.
        addr_sel = 8'h7F;
        push(1, 7, 1);
        tick();
        push(1, 7, 3);
        tick();
        auto_wr = 1'b0;
        live(0, 7, 1);
        tick();
        live_valid = 1'b0;
        check("coll_live_wins", key_data, 5'b11111);
        repeat (4) tick();
        live(1, 7, 2);
        tick();
        live_valid = 1'b0;
        check("coll_both", key_data, 5'b10011);
        live(1, 7, 6);
        tick();
        live_valid = 1'b0;
        check("live_oob", key_data, 5'b10011);
        repeat (3) tick();
        check("coll_idle", busy, 0);

        // Clear during GAP with two entries queued.
        push(1, 7, 4);
        tick();
        push(1, 7, 0);
        tick();
        push(1, 7, 0);
        tick();
        auto_wr = 1'b0;
        check("clr_pre_cnt", auto_count, 2);
        check("clr_pre_kd", key_data, 5'b00011);
        tick();
        auto_clear = 1'b1;
        live(1, 7, 1);
        push(1, 7, 1);
        tick();
        auto_clear = 1'b0;
        live_valid = 1'b0;
        auto_wr    = 1'b0;
        check("clr_cnt", auto_count, 0);
        check("clr_busy", busy, 0);
        check("clr_kd", key_data, 5'b11111);
        check("clr_ovf_held", overflow, 1);
        addr_sel = 8'h00;
        #1;
        check("clr_all_rows", key_data, 5'b11111);
        addr_sel = 8'h7F;
        tick();
        check("clr_stays_idle", busy, 0);

        // Out-of-range auto entry still consumes a slot.
        push(1, 7, 7);
        tick();
        push(1, 7, 0);
        tick();
        auto_wr = 1'b0;
        check("oob_apply_busy", busy, 1);
        tick();
        check("oob_nochange", key_data, 5'b11111);
        check("oob_popped", auto_count, 1);
        repeat (4) tick();
        check("oob_spacing", key_data, 5'b11111);
        tick();
        check("oob_next", key_data, 5'b11110);
        repeat (4) tick();
        check("oob_idle", busy, 0);

        // Reset during APPLY aborts playback.
        push(1, 7, 2);
        tick();
        push(1, 7, 3);
        tick();
        auto_wr = 1'b0;
        check("rst_mid_apply", busy, 1);
        reset = 1'b1;
        tick();
        check("rstm_kd", key_data, 5'b11111);
        check("rstm_cnt", auto_count, 0);
        check("rstm_full", auto_full, 0);
        check("rstm_busy", busy, 0);
        check("rstm_ovf", overflow, 0);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            check($sformatf("rstm_kd_%0d", c), key_data, 5'b11111);
            check($sformatf("rstm_busy_%0d", c), busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
